button_event: RTL and testbench

Classifies the conditioned push-button stream from the debouncer into user-level events: single click, double click, long press, and optional auto-repeat. It sits directly downstream of the debounce stage and consumes its `debounced` level and `strobe` change pulse. It feeds the boot-screen UI controller with single-cycle event pulses.

---
 rtl/button_event.sv | 137 +++++++++++++
 tb/tb_button_event.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Turns the debounced button level/strobe into click, double, long and repeat pulses.
// Define BUTTON_EVENT_REPEAT_EN to build in auto-repeat while a long press is held.
module button_event #(
   parameter int LONG_CYCLES   = 1000,
   parameter int DOUBLE_CYCLES = 300,
   parameter int REPEAT_CYCLES = 200,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic debounced,
   input  logic strobe,
   output logic click,
   output logic double_click,
   output logic long_press,
   output logic repeat_pulse,
   output logic busy
);

   typedef enum logic [2:0] {
      IDLE,
      HELD1,
      LONG,
      WAIT2,
      HELD2
   } state_e;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CYCLES - 1);

   if (LONG_CYCLES < 2 || DOUBLE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
      $error("button_event: cycle parameters must be >= 2");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             click_q, click_d;
   logic             dbl_q, dbl_d;
   logic             long_q, long_d;
   logic             press_ev, release_ev;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic             rep_q, rep_d;
`endif

   assign press_ev   = strobe & debounced;
   assign release_ev = strobe & ~debounced;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (press_ev) state_d = HELD1;
         end
         HELD1: begin
            // release wins over the long threshold in the same cycle
            if (release_ev) begin
               state_d = WAIT2;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
            end
         end
         LONG: begin
            if (release_ev) begin
               state_d = IDLE;
            end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
               if (cnt_q == REP_LAST) begin
                  rep_d = 1'b1;
                  cnt_d = '0;
               end
`else
               cnt_d = '0;
`endif
            end
         end
         WAIT2: begin
            if (press_ev) begin
               state_d = HELD2;
            end else if (cnt_q == DBL_LAST) begin
               state_d = IDLE;
               click_d = 1'b1;
            end
         end
         HELD2: begin
            if (release_ev) begin
               state_d = IDLE;
               dbl_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         click_q <= click_d;
         dbl_q   <= dbl_d;
         long_q  <= long_d;
      end
   end

`ifdef BUTTON_EVENT_REPEAT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rep_q <= 1'b0;
      else          rep_q <= rep_d;
   end

   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign click        = click_q;
   assign double_click = dbl_q;
   assign long_press   = long_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random strobes against
// a timestamp-based reference model.
module tb_button_event;

   localparam int L = 8;
   localparam int D = 5;
   localparam int R = 3;
`ifdef BUTTON_EVENT_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic debounced = 1'b0;
   logic strobe = 1'b0;
   logic click, double_click, long_press, repeat_pulse, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_event #(
      .LONG_CYCLES  (L),
      .DOUBLE_CYCLES(D),
      .REPEAT_CYCLES(R),
      .CNT_W        (16)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .debounced   (debounced),
      .strobe      (strobe),
      .click       (click),
      .double_click(double_click),
      .long_press  (long_press),
      .repeat_pulse(repeat_pulse),
      .busy        (busy)
   );

   typedef enum int {M_IDLE, M_HELD, M_WAIT, M_LONG, M_HELD2} mode_t;
   mode_t mode = M_IDLE;
   int    tp, tr, tl;
   bit    e_click, e_dbl, e_long, e_rep;

   int   ncyc = 0;
   int   base = 0;
   logic lv = 1'b0;
   int   q_click[$], q_dbl[$], q_long[$], q_rep[$];
   int   eq[$];
   int   busy_last;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_q(input string tag, input int q[$], input int e[$]);
      chk({tag, "_count"}, q.size(), e.size());
      for (int i = 0; i < q.size() && i < e.size(); i++)
         chk({tag, "_cycle"}, q[i], e[i]);
   endtask

   // Inputs seen during cycle n decide the expected outputs of cycle n+1.
   function automatic void model_step(bit s, bit d, bit rn, int n);
      bit press, rel;
      int since;
      e_click = 0;
      e_dbl   = 0;
      e_long  = 0;
      e_rep   = 0;
      if (!rn) begin
         mode = M_IDLE;
         return;
      end
      press = s && d;
      rel   = s && !d;
      case (mode)
         M_IDLE: if (press) begin mode = M_HELD; tp = n; end
         M_HELD: begin
            if (rel) begin
               mode = M_WAIT;
               tr   = n;
            end else if (n - tp == L) begin
               mode   = M_LONG;
               e_long = 1;
               tl     = n + 1;
            end
         end
         M_LONG: begin
            since = n + 1 - tl;
            if (rel) mode = M_IDLE;
            else if (REP && since > 0 && since % R == 0) e_rep = 1;
         end
         M_WAIT: begin
            if (press) begin
               mode = M_HELD2;
            end else if (n - tr == D) begin
               mode    = M_IDLE;
               e_click = 1;
            end
         end
         M_HELD2: if (rel) begin mode = M_IDLE; e_dbl = 1; end
         default: mode = M_IDLE;
      endcase
   endfunction

   task automatic step(input bit s, input bit d, input bit rn);
      int rc;
      strobe    = s;
      debounced = d;
      reset_n   = rn;
      #1;
      if (!rn) begin
         mode    = M_IDLE;
         e_click = 0;
         e_dbl   = 0;
         e_long  = 0;
         e_rep   = 0;
      end
      chk("click", click, e_click);
      chk("double_click", double_click, e_dbl);
      chk("long_press", long_press, e_long);
      chk("repeat", repeat_pulse, e_rep);
      chk("busy", busy, mode != M_IDLE);
      rc = ncyc - base;
      if (click) q_click.push_back(rc);
      if (double_click) q_dbl.push_back(rc);
      if (long_press) q_long.push_back(rc);
      if (repeat_pulse) q_rep.push_back(rc);
      if (busy) busy_last = rc;
      @(posedge clk);
      model_step(s, d, rn, ncyc);
      ncyc++;
      #1;
   endtask

   task automatic idle_to(input int c);
      while (ncyc - base < c) step(1'b0, lv, 1'b1);
   endtask

   task automatic press_at(input int c);
      idle_to(c);
      lv = 1'b1;
      step(1'b1, 1'b1, 1'b1);
   endtask

   task automatic release_at(input int c);
      idle_to(c);
      lv = 1'b0;
      step(1'b1, 1'b0, 1'b1);
   endtask

   task automatic scn_begin();
      lv = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      q_click.delete();
      q_dbl.delete();
      q_long.delete();
      q_rep.delete();
      busy_last = -1;
      base = ncyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      int r;
      int gap;
      @(posedge clk);
      #1;

      // short click
      scn_begin();
      press_at(10);
      release_at(13);
      idle_to(30);
      eq = {19};
      chk_q("s1_click", q_click, eq);
      eq = {};
      chk_q("s1_dbl", q_dbl, eq);
      chk_q("s1_long", q_long, eq);
      chk_q("s1_rep", q_rep, eq);
      chk("s1_busy_last", busy_last, 18);

      // double click with second press on the window boundary
      scn_begin();
      press_at(10);
      release_at(13);
      press_at(18);
      release_at(21);
      idle_to(30);
      eq = {22};
      chk_q("s2_dbl", q_dbl, eq);
      eq = {};
      chk_q("s2_click", q_click, eq);
      chk_q("s2_long", q_long, eq);

      // long hold
      scn_begin();
      press_at(10);
      release_at(30);
      idle_to(45);
      eq = {19};
      chk_q("s3_long", q_long, eq);
      if (REP) eq = {22, 25, 28};
      else eq = {};
      chk_q("s3_rep", q_rep, eq);
      eq = {};
      chk_q("s3_click", q_click, eq);
      chk_q("s3_dbl", q_dbl, eq);

      // release on the long threshold cycle
      scn_begin();
      press_at(10);
      release_at(18);
      idle_to(35);
      eq = {};
      chk_q("s5_long", q_long, eq);
      eq = {24};
      chk_q("s5_click", q_click, eq);

      // reset while waiting for a second press
      scn_begin();
      press_at(10);
      release_at(13);
      idle_to(15);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      press_at(20);
      release_at(23);
      idle_to(40);
      eq = {29};
      chk_q("s6_click", q_click, eq);
      eq = {};
      chk_q("s6_dbl", q_dbl, eq);
      chk_q("s6_long", q_long, eq);

      // random strobes, spurious strobes and resets
      scn_begin();
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            repeat ($urandom_range(1, 2)) step(1'b0, lv, 1'b0);
         end else begin
            gap = $urandom_range(0, 11);
            repeat (gap) step(1'b0, lv, 1'b1);
            if (r < 10) begin
               step(1'b1, lv, 1'b1);
            end else begin
               lv = ~lv;
               step(1'b1, lv, 1'b1);
            end
         end
      end
      repeat (20) step(1'b0, lv, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
